trap_ctrl: RTL and testbench
============================

# trap_ctrl

Parametrised machine-mode trap controller for the write-back stage. It owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch) and prioritises exceptions, standard interrupts and NUM_LOCAL_IRQ platform interrupts. It kills the retiring instruction and holds a redirect request until fetch accepts it. It also supports mret and optional vectored trap dispatch.

## Interface
- NUM_LOCAL_IRQ, 4: local interrupt lines, legal range 0..16; line i has cause 16+i.
- RESET_MTVEC, 32'h0000_0100: mtvec reset value.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-low reset.
- retire_valid_i  in  1  instruction in write-back this cycle.
- pc_i  in  32  PC of the retiring instruction.
- instr_i  in  32  retiring instruction word.
- mem_addr_i  in  32  load/store effective address.
- exc_i  in  6  {ecall, st_mis, ld_mis, ebreak, illegal, inst_mis}.
- mret_i  in  1  retiring instruction is mret.
- irq_m_i  in  3  {meip, mtip, msip}, level-sensitive.
- irq_local_i  in  NUM_LOCAL_IRQ (min 1)  level-sensitive local interrupts.
- csr_we_i  in  1  CSR write strobe, qualified by retire_valid_i.
- csr_addr_i  in  12  CSR address.
- csr_wdata_i  in  32  final write value; read-modify-write is resolved upstream.
- csr_rdata_o  out  32  combinational read data.
- csr_illegal_o  out  1  csr_addr_i is not owned by this block.
- kill_o  out  1  suppress the register-file write of the retiring instruction.
- redirect_valid_o  out  1  PC redirect pending.
- redirect_ready_i  in  1  fetch accepts the redirect.
- redirect_pc_o  out  32  redirect target.

## Operation
- Event selection (highest priority first):
  - exception;
  - else pending-and-enabled interrupt while mstatus.MIE=1;
  - else mret.
- Events are evaluated only when retire_valid_i=1 and state=RUN.
- Exception priority and mcause/mtval:
  - inst_mis: cause 0, mtval=pc_i.
  - illegal: cause 2, mtval=instr_i.
  - ebreak: cause 3, mtval=0.
  - ld_mis: cause 4, mtval=mem_addr_i.
  - st_mis: cause 6, mtval=mem_addr_i.
  - ecall: cause 11, mtval=0.
- Interrupt priority:
  - MEI (cause 11), then MSI (3), then MTI (7).
  - Then local lines, highest index first, cause 16+i.
  - Interrupt mcause has bit31=1; mtval=0.
- Trap entry on the clock edge:
  - mepc<=pc_i with bits[1:0] forced to 0.
  - mcause and mtval <= the encoded values above.
  - MPIE<=MIE, MIE<=0.
  - kill_o=1 in the same cycle.
- mret: MIE<=MPIE, MPIE<=1, target=mepc, kill_o=0.
- mip is read-only and reflects the live lines: bit11=meip, bit7=mtip, bit3=msip, bit16+i=irq_local_i[i].
- Writable mie bits: 3, 7, 11, 16..16+NUM_LOCAL_IRQ-1. All other bits read as 0.
- mstatus.MPP is hardwired to 2'b11. Only MIE (bit3) and MPIE (bit7) are writable.
- mtvec: BASE is [31:2]; bit1 reads as 0.
- A CSR write in the same cycle as a trap is discarded; the trap update wins.
- State machine:
  - RUN -> REDIRECT on trap or mret.
  - REDIRECT -> RUN when redirect_ready_i=1.
- In REDIRECT:
  - kill_o=1 for every retire_valid_i.
  - Events and CSR writes are ignored.
  - redirect_pc_o is held stable.

## Timing
- Reset values:
  - mstatus=32'h0000_1800, mie=0, mepc=0, mcause=0, mtval=0, mscratch=0.
  - mtvec=RESET_MTVEC.
  - state=RUN, redirect_valid_o=0, redirect_pc_o=0.
- Latency: event in cycle N produces, in cycle N+1:
  - CSR updates visible;
  - redirect_valid_o=1.
- Handshake: transfer occurs on the edge where valid and ready are both 1; redirect_valid_o drops the next cycle.
- Back-to-back: a new event may be taken in the cycle after transfer.
- Reset asserted mid-REDIRECT: returns to RUN immediately, drops redirect_valid_o, and loses the pending redirect.
- An interrupt line deasserted before retire is not taken; there is no edge latching.

## Configuration
- TRAP_VECTORED_EN defined:
  - mtvec.MODE (bit0) is writable.
  - With MODE=1, the interrupt target is BASE + 4*cause[4:0].
  - Exceptions and MODE=0 use BASE.
- TRAP_VECTORED_EN undefined: bit0 reads as 0, writes to it are ignored, and every trap targets BASE.

## Structure
- Shared package trap_pkg holds:
  - cause code constants;
  - CSR address constants (0x300, 0x304, 0x305, 0x340–0x344);
  - the exc_i bit indices;
  - the two-state enum.
- Sub-module irq_arbiter (combinational): masks mip with mie and MIE, applies the interrupt priority, and returns valid + 5-bit cause.

## Test plan
- mie=0x808, MIE=1, meip and msip both high, retire at pc 0x200 -> mcause=0x8000000B, mepc=0x200, MIE=0, MPIE=1, kill_o=1, redirect_pc_o=mtvec base.
- Illegal instruction 0xFFFFFFFF plus a pending enabled interrupt -> mcause=2, mtval=0xFFFFFFFF; the interrupt remains pending.
- NUM_LOCAL_IRQ=4, local[3] enabled, TRAP_VECTORED_EN set, mtvec=0x1001 -> redirect_pc_o=0x1000+4*19=0x104C.
- mret with mepc=0x400 and MPIE=1 -> MIE=1, redirect_pc_o=0x400. With ready held low for 3 cycles, valid and pc stay stable and retires are killed.
- CSR write to mie in the same cycle as ecall -> mie unchanged, mcause=11.
- rst_i low during REDIRECT -> redirect_valid_o=0 and mtvec=RESET_MTVEC on the next sample.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared constants and types for the machine-mode trap controller: CSR
// addresses, cause codes, exc_i bit positions and the controller state enum.
package trap_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;

   // Bit positions inside exc_i = {ecall, st_mis, ld_mis, ebreak, illegal, inst_mis}
   localparam int EXC_INST_MIS = 0;
   localparam int EXC_ILLEGAL  = 1;
   localparam int EXC_EBREAK   = 2;
   localparam int EXC_LD_MIS   = 3;
   localparam int EXC_ST_MIS   = 4;
   localparam int EXC_ECALL    = 5;

   localparam logic [4:0] CAUSE_INST_MIS   = 5'd0;
   localparam logic [4:0] CAUSE_ILLEGAL    = 5'd2;
   localparam logic [4:0] CAUSE_EBREAK     = 5'd3;
   localparam logic [4:0] CAUSE_LD_MIS     = 5'd4;
   localparam logic [4:0] CAUSE_ST_MIS     = 5'd6;
   localparam logic [4:0] CAUSE_ECALL      = 5'd11;
   localparam logic [4:0] CAUSE_MSI        = 5'd3;
   localparam logic [4:0] CAUSE_MTI        = 5'd7;
   localparam logic [4:0] CAUSE_MEI        = 5'd11;
   localparam logic [4:0] CAUSE_LOCAL_BASE = 5'd16;

   localparam int MIP_MSIP  = 3;
   localparam int MIP_MTIP  = 7;
   localparam int MIP_MEIP  = 11;
   localparam int MIP_LOCAL = 16;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_REDIRECT = 1'b1
   } state_e;

   // Writable bits of mie (and the implemented bits of mip) for n local lines.
   function automatic logic [31:0] mie_mask(input int n);
      logic [31:0] m;
      m = '0;
      m[MIP_MSIP] = 1'b1;
      m[MIP_MTIP] = 1'b1;
      m[MIP_MEIP] = 1'b1;
      for (int i = 0; i < 16; i++) begin
         if (i < n) m[MIP_LOCAL + i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/irq_arbiter.sv
// Combinational interrupt arbiter: masks pending lines with mie and the global
// enable, then picks MEI > MSI > MTI > local lines (highest index first).
module irq_arbiter
   import trap_pkg::*;
#(
   parameter int NUM_LOCAL_IRQ = 4
) (
   input  logic [31:0] mip,
   input  logic [31:0] mie,
   input  logic        global_en,
   output logic        valid,
   output logic [4:0]  cause
);

   logic [31:0] pend;

   always_comb begin
      pend  = mip & mie & {32{global_en}};
      valid = 1'b0;
      cause = '0;
      if (pend[MIP_MEIP]) begin
         valid = 1'b1;
         cause = CAUSE_MEI;
      end else if (pend[MIP_MSIP]) begin
         valid = 1'b1;
         cause = CAUSE_MSI;
      end else if (pend[MIP_MTIP]) begin
         valid = 1'b1;
         cause = CAUSE_MTI;
      end else begin
         // Ascending scan so the highest pending index is the one that sticks.
         for (int i = 0; i < 16; i++) begin
            if (i < NUM_LOCAL_IRQ && pend[MIP_LOCAL + i]) begin
               valid = 1'b1;
               cause = CAUSE_LOCAL_BASE + 5'(i);
            end
         end
      end
   end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller for write-back: trap CSRs, event priority,
// kill and held redirect. Vectored interrupt dispatch when TRAP_VECTORED_EN.
module trap_ctrl
   import trap_pkg::*;
#(
   parameter int          NUM_LOCAL_IRQ = 4,
   parameter logic [31:0] RESET_MTVEC   = 32'h0000_0100
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            retire_valid_i,
   input  logic [31:0]                                     pc_i,
   input  logic [31:0]                                     instr_i,
   input  logic [31:0]                                     mem_addr_i,
   input  logic [5:0]                                      exc_i,
   input  logic                                            mret_i,
   input  logic [2:0]                                      irq_m_i,
   input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local_i,
   input  logic                                            csr_we_i,
   input  logic [11:0]                                     csr_addr_i,
   input  logic [31:0]                                     csr_wdata_i,
   output logic [31:0]                                     csr_rdata_o,
   output logic                                            csr_illegal_o,
   output logic                                            kill_o,
   output logic                                            redirect_valid_o,
   input  logic                                            redirect_ready_i,
   output logic [31:0]                                     redirect_pc_o,
   output state_e                                          state_o
);

   localparam logic [31:0] MIE_MASK = mie_mask(NUM_LOCAL_IRQ);

   // Handshake: redirect_valid_o is high for the whole REDIRECT state and
   // redirect_pc_o is stable while it is high; the redirect transfers on the
   // clock edge where redirect_valid_o and redirect_ready_i are both 1.
   state_e      state, state_nxt;
   logic        mstatus_mie, mstatus_mpie;
   logic [31:0] mie_reg, mepc, mcause, mtval, mscratch, redirect_pc;
   logic [29:0] mtvec_base;
   logic        mtvec_mode;
   logic [31:0] mip, mstatus, mtvec;
   logic [15:0] local_ext;
   logic        irq_valid;
   logic [4:0]  irq_cause;
   logic        act, exc_any, take_exc, take_irq, take_mret, trap, csr_wr;
   logic [4:0]  exc_cause;
   logic [31:0] exc_tval, trap_cause, trap_tval, target, vec_offset;

   assign local_ext = 16'(irq_local_i);

   always_comb begin
      mip = {local_ext, 16'h0000} & MIE_MASK;
      mip[MIP_MSIP] = irq_m_i[0];
      mip[MIP_MTIP] = irq_m_i[1];
      mip[MIP_MEIP] = irq_m_i[2];
   end

   assign mstatus = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
   assign mtvec   = {mtvec_base, 1'b0, mtvec_mode};

   irq_arbiter #(
      .NUM_LOCAL_IRQ(NUM_LOCAL_IRQ)
   ) u_irq_arbiter (
      .mip      (mip),
      .mie      (mie_reg),
      .global_en(mstatus_mie),
      .valid    (irq_valid),
      .cause    (irq_cause)
   );

   always_comb begin
      exc_cause = CAUSE_ECALL;
      exc_tval  = '0;
      if (exc_i[EXC_INST_MIS]) begin
         exc_cause = CAUSE_INST_MIS;
         exc_tval  = pc_i;
      end else if (exc_i[EXC_ILLEGAL]) begin
         exc_cause = CAUSE_ILLEGAL;
         exc_tval  = instr_i;
      end else if (exc_i[EXC_EBREAK]) begin
         exc_cause = CAUSE_EBREAK;
      end else if (exc_i[EXC_LD_MIS]) begin
         exc_cause = CAUSE_LD_MIS;
         exc_tval  = mem_addr_i;
      end else if (exc_i[EXC_ST_MIS]) begin
         exc_cause = CAUSE_ST_MIS;
         exc_tval  = mem_addr_i;
      end
   end

   assign act       = retire_valid_i && (state == ST_RUN);
   assign exc_any   = |exc_i;
   assign take_exc  = act && exc_any;
   assign take_irq  = act && !exc_any && irq_valid;
   assign take_mret = act && !exc_any && !irq_valid && mret_i;
   assign trap      = take_exc || take_irq;
   // Any event in the same cycle discards the CSR write.
   assign csr_wr    = act && csr_we_i && !trap && !take_mret;

   assign trap_cause = take_exc ? {27'b0, exc_cause} : {1'b1, 26'b0, irq_cause};
   assign trap_tval  = take_exc ? exc_tval : 32'h0;

`ifdef TRAP_VECTORED_EN
   assign vec_offset = (take_irq && mtvec_mode) ? {25'b0, irq_cause, 2'b00} : 32'h0;
`else
   assign vec_offset = 32'h0;
`endif

   assign target = trap ? ({mtvec_base, 2'b00} + vec_offset) : mepc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state <= ST_RUN;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      kill_o           = 1'b0;
      redirect_valid_o = 1'b0;
      case (state)
         ST_RUN: begin
            kill_o = trap;
            if (trap || take_mret) state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            kill_o           = retire_valid_i;
            redirect_valid_o = 1'b1;
            if (redirect_ready_i) state_nxt = ST_RUN;
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   assign state_o       = state;
   assign redirect_pc_o = redirect_pc;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) redirect_pc <= '0;
      else if (trap || take_mret) redirect_pc <= target;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_reg      <= '0;
         mtvec_base   <= RESET_MTVEC[31:2];
         mepc         <= '0;
         mcause       <= '0;
         mtval        <= '0;
         mscratch     <= '0;
      end else if (trap) begin
         mepc         <= {pc_i[31:2], 2'b00};
         mcause       <= trap_cause;
         mtval        <= trap_tval;
         mstatus_mpie <= mstatus_mie;
         mstatus_mie  <= 1'b0;
      end else if (take_mret) begin
         mstatus_mie  <= mstatus_mpie;
         mstatus_mpie <= 1'b1;
      end else if (csr_wr) begin
         case (csr_addr_i)
            CSR_MSTATUS: begin
               mstatus_mie  <= csr_wdata_i[3];
               mstatus_mpie <= csr_wdata_i[7];
            end
            CSR_MIE:      mie_reg    <= csr_wdata_i & MIE_MASK;
            CSR_MTVEC:    mtvec_base <= csr_wdata_i[31:2];
            CSR_MSCRATCH: mscratch   <= csr_wdata_i;
            CSR_MEPC:     mepc       <= {csr_wdata_i[31:2], 2'b00};
            CSR_MCAUSE:   mcause     <= csr_wdata_i;
            CSR_MTVAL:    mtval      <= csr_wdata_i;
            default: ;
         endcase
      end
   end

`ifdef TRAP_VECTORED_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) mtvec_mode <= RESET_MTVEC[0];
      else if (csr_wr && csr_addr_i == CSR_MTVEC) mtvec_mode <= csr_wdata_i[0];
   end
`else
   assign mtvec_mode = 1'b0;
`endif

   always_comb begin
      csr_rdata_o   = '0;
      csr_illegal_o = 1'b0;
      case (csr_addr_i)
         CSR_MSTATUS:  csr_rdata_o = mstatus;
         CSR_MIE:      csr_rdata_o = mie_reg;
         CSR_MTVEC:    csr_rdata_o = mtvec;
         CSR_MSCRATCH: csr_rdata_o = mscratch;
         CSR_MEPC:     csr_rdata_o = mepc;
         CSR_MCAUSE:   csr_rdata_o = mcause;
         CSR_MTVAL:    csr_rdata_o = mtval;
         CSR_MIP:      csr_rdata_o = mip;
         default:      csr_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: expected redirect targets are queued when an
// event is driven and popped when the redirect appears.
module tb_trap_ctrl;
  import trap_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        retire_valid_i;
  logic [31:0] pc_i, instr_i, mem_addr_i;
  logic [5:0]  exc_i;
  logic        mret_i;
  logic [2:0]  irq_m_i;
  logic [3:0]  irq_local_i;
  logic        csr_we_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [31:0] csr_rdata_o;
  logic        csr_illegal_o, kill_o, redirect_valid_o, redirect_ready_i;
  logic [31:0] redirect_pc_o;
  state_e      state_o;

  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] rd;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] VEC_TARGET = 32'h0000_104C;
  localparam logic [31:0] MTVEC_1001 = 32'h0000_1001;
  localparam logic [31:0] MTVEC_203  = 32'h0000_0201;
`else
  localparam logic [31:0] VEC_TARGET = 32'h0000_1000;
  localparam logic [31:0] MTVEC_1001 = 32'h0000_1000;
  localparam logic [31:0] MTVEC_203  = 32'h0000_0200;
`endif

  trap_ctrl #(.NUM_LOCAL_IRQ(4), .RESET_MTVEC(32'h0000_0100)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .retire_valid_i(retire_valid_i), .pc_i(pc_i),
    .instr_i(instr_i), .mem_addr_i(mem_addr_i), .exc_i(exc_i), .mret_i(mret_i),
    .irq_m_i(irq_m_i), .irq_local_i(irq_local_i), .csr_we_i(csr_we_i),
    .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i), .csr_rdata_o(csr_rdata_o),
    .csr_illegal_o(csr_illegal_o), .kill_o(kill_o), .redirect_valid_o(redirect_valid_o),
    .redirect_ready_i(redirect_ready_i), .redirect_pc_o(redirect_pc_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle();
    retire_valid_i = 1'b0; pc_i = '0; instr_i = '0; mem_addr_i = '0;
    exc_i = '0; mret_i = 1'b0; csr_we_i = 1'b0; csr_addr_i = '0;
    csr_wdata_i = '0; redirect_ready_i = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    retire_valid_i = 1'b1; csr_we_i = 1'b1; csr_addr_i = a; csr_wdata_i = d;
    tick();
    idle();
  endtask

  task automatic csr_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_addr_i = a;
    #1;
    check(tag, csr_rdata_o, exp);
  endtask

  // Drive one retiring instruction with an event; target goes to the scoreboard.
  task automatic retire_evt(input string tag, input logic [31:0] pc, input logic [5:0] exc,
                            input logic mret, input logic [31:0] instr,
                            input logic [31:0] exp_target, input logic exp_kill);
    retire_valid_i = 1'b1; pc_i = pc; exc_i = exc; mret_i = mret; instr_i = instr;
    exp_q.push_back(exp_target);
    #1;
    check({tag, "_kill"}, 32'(kill_o), 32'(exp_kill));
    tick();
    idle();
  endtask

  task automatic expect_redirect(input string tag);
    logic [31:0] exp;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check({tag, "_valid"}, 32'(redirect_valid_o), 32'd1);
    check({tag, "_pc"}, redirect_pc_o, exp);
  endtask

  task automatic accept(input string tag);
    redirect_ready_i = 1'b1;
    tick();
    redirect_ready_i = 1'b0;
    check({tag, "_drop"}, 32'(redirect_valid_o), 32'd0);
    check({tag, "_state"}, 32'(state_o), 32'(ST_RUN));
  endtask

  initial begin
    rst_i = 1'b0; irq_m_i = '0; irq_local_i = '0;
    idle();
    repeat (3) tick();

    check("rst_valid", 32'(redirect_valid_o), 32'd0);
    check("rst_pc", redirect_pc_o, 32'h0);
    check("rst_state", 32'(state_o), 32'(ST_RUN));
    csr_check("rst_mstatus", CSR_MSTATUS, 32'h0000_1800);
    csr_check("rst_mtvec", CSR_MTVEC, 32'h0000_0100);
    csr_check("rst_mie", CSR_MIE, 32'h0);
    csr_check("rst_mepc", CSR_MEPC, 32'h0);
    csr_check("rst_mcause", CSR_MCAUSE, 32'h0);
    tick();
    rst_i = 1'b1;
    tick();

    // CSR write masks and address decode
    csr_write(CSR_MIE, 32'hFFFF_FFFF);
    csr_check("mie_mask", CSR_MIE, 32'h000F_0888);
    csr_write(CSR_MSTATUS, 32'hFFFF_FFFF);
    csr_check("mstatus_mask", CSR_MSTATUS, 32'h0000_1888);
    csr_write(CSR_MTVEC, 32'h0000_0203);
    csr_check("mtvec_mask", CSR_MTVEC, MTVEC_203);
    csr_write(CSR_MSCRATCH, 32'hA5A5_5A5A);
    csr_check("mscratch_rw", CSR_MSCRATCH, 32'hA5A5_5A5A);
    csr_addr_i = 12'h7C0; #1;
    check("illegal_addr", 32'(csr_illegal_o), 32'd1);
    csr_addr_i = CSR_MIP; #1;
    check("legal_addr", 32'(csr_illegal_o), 32'd0);
    csr_write(CSR_MTVEC, 32'h0000_0100);
    csr_write(CSR_MIE, 32'h0000_0808);
    csr_write(CSR_MSTATUS, 32'h0000_0008);

    // MEI beats MSI
    irq_m_i = 3'b101;
    csr_check("mip_live", CSR_MIP, 32'h0000_0808);
    retire_evt("mei", 32'h0000_0200, 6'b0, 1'b0, 32'h0, 32'h0000_0100, 1'b1);
    expect_redirect("mei");
    csr_check("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_check("mei_mepc", CSR_MEPC, 32'h0000_0200);
    csr_check("mei_mstatus", CSR_MSTATUS, 32'h0000_1880);
    csr_check("mei_mtval", CSR_MTVAL, 32'h0);
    accept("mei");

    // With MIE cleared, a pending line must not be taken.
    retire_valid_i = 1'b1; pc_i = 32'h0000_0204; #1;
    check("masked_kill", 32'(kill_o), 32'd0);
    tick();
    idle();
    check("masked_novalid", 32'(redirect_valid_o), 32'd0);
    irq_m_i = 3'b000;

    // Illegal instruction beats a pending, enabled interrupt
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    irq_m_i = 3'b001;
    retire_evt("ill", 32'h0000_0300, 6'b000010, 1'b0, 32'hFFFF_FFFF, 32'h0000_0100, 1'b1);
    expect_redirect("ill");
    csr_check("ill_mcause", CSR_MCAUSE, 32'h0000_0002);
    csr_check("ill_mtval", CSR_MTVAL, 32'hFFFF_FFFF);
    csr_check("ill_mepc", CSR_MEPC, 32'h0000_0300);
    csr_check("ill_mip", CSR_MIP, 32'h0000_0008);
    accept("ill");
    irq_m_i = 3'b000;

    // Local line 3 beats local line 0, vectored when enabled; mepc aligned
    csr_write(CSR_MTVEC, 32'h0000_1001);
    csr_check("mtvec_1001", CSR_MTVEC, MTVEC_1001);
    csr_write(CSR_MIE, 32'h0009_0000);
    csr_write(CSR_MSTATUS, 32'h0000_0008);
    irq_local_i = 4'b1001;
    retire_evt("loc3", 32'h0000_0502, 6'b0, 1'b0, 32'h0, VEC_TARGET, 1'b1);
    expect_redirect("loc3");
    csr_check("loc3_mcause", CSR_MCAUSE, 32'h8000_0013);
    csr_check("loc3_mepc", CSR_MEPC, 32'h0000_0500);
    accept("loc3");
    irq_local_i = 4'b0000;

    // mret, redirect held for 3 cycles with ready low
    csr_write(CSR_MEPC, 32'h0000_0400);
    retire_evt("mret", 32'h0000_0600, 6'b0, 1'b1, 32'h0, 32'h0000_0400, 1'b0);
    expect_redirect("mret");
    csr_check("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);
    for (int i = 0; i < 3; i++) begin
      retire_valid_i = 1'b1; exc_i = 6'b100000; pc_i = 32'h0000_0800;
      csr_we_i = 1'b1; csr_addr_i = CSR_MSCRATCH; csr_wdata_i = 32'h0000_1234;
      #1;
      check("hold_kill", 32'(kill_o), 32'd1);
      tick();
      idle();
      check("hold_valid", 32'(redirect_valid_o), 32'd1);
      check("hold_pc", redirect_pc_o, 32'h0000_0400);
    end
    csr_check("hold_mcause", CSR_MCAUSE, 32'h8000_0013);
    csr_check("hold_mscratch", CSR_MSCRATCH, 32'hA5A5_5A5A);
    accept("mret");

    // CSR write to mie discarded when ecall traps in the same cycle
    retire_valid_i = 1'b1; pc_i = 32'h0000_0700; exc_i = 6'b100000;
    csr_we_i = 1'b1; csr_addr_i = CSR_MIE; csr_wdata_i = 32'hFFFF_FFFF;
    exp_q.push_back(32'h0000_1000);
    #1;
    check("ecall_kill", 32'(kill_o), 32'd1);
    tick();
    idle();
    expect_redirect("ecall");
    csr_check("ecall_mie", CSR_MIE, 32'h0009_0000);
    csr_check("ecall_mcause", CSR_MCAUSE, 32'h0000_000B);
    csr_check("ecall_mtval", CSR_MTVAL, 32'h0);

    // Reset while the redirect is still pending
    rst_i = 1'b0;
    #1;
    check("midrst_valid", 32'(redirect_valid_o), 32'd0);
    check("midrst_state", 32'(state_o), 32'(ST_RUN));
    check("midrst_pc", redirect_pc_o, 32'h0);
    csr_check("midrst_mtvec", CSR_MTVEC, 32'h0000_0100);
    tick();
    rst_i = 1'b1;
    tick();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
